cond_pred_unit: RTL and testbench

- Parametrised successor to the single-zero-flag condition logic.
- Holds a full NZCV flag register with split write enables and evaluates a 4-bit condition code per instruction.
- Adds a predicated-block state machine: one start instruction predicates the next 1..MAX_BLOCK instructions with a then/else mask.
- Sits between decode and the writeback, PC and memory enables; it gates PCSrc, RegWrite and MemWrite.

---
 rtl/cond_pkg.sv | 66 ++++++
 rtl/cond_check.sv | 12 +
 rtl/flopenr.sv | 17 +
 rtl/cond_pred_unit.sv | 139 +++++++++++++
 tb/tb_cond_pred_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared types, flag indices and the condition-code evaluator for the
// conditional/predicated execution unit.
package cond_pkg;

  localparam int FLAG_W_C = 4;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic cond_eval(input logic [3:0] cond,
                                     input logic [FLAG_W_C-1:0] flags);
    logic n, z, c, v;
    logic res;
    n   = flags[N_IDX];
    z   = flags[Z_IDX];
    c   = flags[C_IDX];
    v   = flags[V_IDX];
    res = 1'b0;
    case (cond)
      EQ:      res = z;
      NE:      res = ~z;
      CS:      res = c;
      CC:      res = ~c;
      MI:      res = n;
      PL:      res = ~n;
      VS:      res = v;
      VC:      res = ~v;
      HI:      res = c & ~z;
      LS:      res = ~c | z;
      GE:      res = (n == v);
      LT:      res = (n != v);
      GT:      res = ~z & (n == v);
      LE:      res = z | (n != v);
      AL:      res = 1'b1;
      default: res = 1'b0;   // NV: never executes
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code check against a flag vector.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0]          cond,
  input  logic [FLAG_W_C-1:0] flags,
  output logic                pass
);

  assign pass = cond_eval(cond, flags);

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cond_pred_unit.sv
// Condition evaluation, NZCV flag register and predicated-block sequencer;
// gates PC, register and memory writes from decode.
//
// state  | meaning
// IDLE   | no block open; instructions judged by their own cond only
// ACTIVE | block open; each valid instruction consumes one predicated slot
module cond_pred_unit
  import cond_pkg::*;
#(
  parameter int FLAG_W    = 4,
  parameter int MAX_BLOCK = 4,
  parameter int CNT_W     = $clog2(MAX_BLOCK + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instrValid,
  input  logic [3:0]           cond,
  input  logic [FLAG_W-1:0]    aluFlags,
  input  logic [1:0]           flagWrite,
  input  logic                 PCS,
  input  logic                 regW,
  input  logic                 memW,
  input  logic                 noWrite,
  input  logic                 blockStart,
  input  logic [3:0]           blockCond,
  input  logic [CNT_W-1:0]     blockLen,
  input  logic [MAX_BLOCK-1:0] blockMask,
  output logic                 PCSrc,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [FLAG_W-1:0]    flags,
  output logic                 condEx,
  output logic                 blockActive,
  output logic [CNT_W-1:0]     blockRemain,
  output logic                 blockErr
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BLOCK);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     remain_q, remain_d;
  logic [MAX_BLOCK-1:0] mask_q, mask_d;
  logic [3:0]           bcond_q, bcond_d;

  logic       in_block;
  logic       instr_pass;
  logic       slot_pass;
  logic [3:0] slot_cond;
  logic       cond_ex;
  logic [CNT_W-1:0] len_clamped;

  assign in_block = (state_q == ACTIVE);

  // Else-slots test the inverse condition; inverting AL lands on NV (never).
  assign slot_cond = mask_q[0] ? bcond_q : (bcond_q ^ 4'b0001);

  cond_check u_instr_check (
    .cond  (cond),
    .flags (flags),
    .pass  (instr_pass)
  );

  cond_check u_slot_check (
    .cond  (slot_cond),
    .flags (flags),
    .pass  (slot_pass)
  );

  assign cond_ex  = instrValid & ~reset & instr_pass & (~in_block | slot_pass);
  assign condEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = regW & cond_ex & ~noWrite;
  assign MemWrite = memW & cond_ex;
  assign blockErr = instrValid & ~reset & blockStart & in_block;

  assign blockActive = in_block;
  assign blockRemain = remain_q;

  flopenr #(.WIDTH(2)) u_flags_nz (
    .clk   (clk),
    .reset (reset),
    .en    (cond_ex & flagWrite[1]),
    .d     (aluFlags[N_IDX:Z_IDX]),
    .q     (flags[N_IDX:Z_IDX])
  );

  flopenr #(.WIDTH(2)) u_flags_cv (
    .clk   (clk),
    .reset (reset),
    .en    (cond_ex & flagWrite[0]),
    .d     (aluFlags[C_IDX:V_IDX]),
    .q     (flags[C_IDX:V_IDX])
  );

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    mask_d      = mask_q;
    bcond_d     = bcond_q;
    len_clamped = (blockLen > MAX_LEN) ? MAX_LEN : blockLen;
    case (state_q)
      IDLE: begin
        if (instrValid && blockStart && cond_ex && (blockLen != '0)) begin
          state_d  = ACTIVE;
          remain_d = len_clamped;
          mask_d   = blockMask;
          bcond_d  = blockCond;
        end
      end
      ACTIVE: begin
        // A nested start is treated as an ordinary slot.
        if (instrValid) begin
          mask_d   = mask_q >> 1;
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = IDLE;
            mask_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      remain_q <= '0;
      mask_q   <= '0;
      bcond_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      mask_q   <= mask_d;
      bcond_q  <= bcond_d;
    end
  end

endmodule

// File: tb/tb_cond_pred_unit.sv
// Self-checking bench for cond_pred_unit: directed scenarios plus a random
// run against a queue-based behavioural model.
module tb_cond_pred_unit;

  localparam int MAX_BLOCK = 4;
  localparam int CNT_W     = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 instrValid;
  logic [3:0]           cond;
  logic [3:0]           aluFlags;
  logic [1:0]           flagWrite;
  logic                 PCS, regW, memW, noWrite;
  logic                 blockStart;
  logic [3:0]           blockCond;
  logic [CNT_W-1:0]     blockLen;
  logic [MAX_BLOCK-1:0] blockMask;
  logic                 PCSrc, RegWrite, MemWrite;
  logic [3:0]           flags;
  logic                 condEx, blockActive, blockErr;
  logic [CNT_W-1:0]     blockRemain;

  always #5 clk = ~clk;

  cond_pred_unit #(.FLAG_W(4), .MAX_BLOCK(MAX_BLOCK), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instrValid  (instrValid),
    .cond        (cond),
    .aluFlags    (aluFlags),
    .flagWrite   (flagWrite),
    .PCS         (PCS),
    .regW        (regW),
    .memW        (memW),
    .noWrite     (noWrite),
    .blockStart  (blockStart),
    .blockCond   (blockCond),
    .blockLen    (blockLen),
    .blockMask   (blockMask),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .flags       (flags),
    .condEx      (condEx),
    .blockActive (blockActive),
    .blockRemain (blockRemain),
    .blockErr    (blockErr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: flags as four bits, the open block as a queue of slot polarities.
  bit m_n, m_z, m_c, m_v;
  bit m_slots[$];
  int m_bcond;
  bit e_cond_ex, e_err, e_pcsrc, e_regw, e_memw;

  function automatic bit m_eval(int c);
    case (c)
      0:  return m_z;
      1:  return !m_z;
      2:  return m_c;
      3:  return !m_c;
      4:  return m_n;
      5:  return !m_n;
      6:  return m_v;
      7:  return !m_v;
      8:  return m_c && !m_z;
      9:  return !m_c || m_z;
      10: return m_n == m_v;
      11: return m_n != m_v;
      12: return !m_z && (m_n == m_v);
      13: return m_z || (m_n != m_v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_expect();
    bit slot_ok;
    slot_ok = 1'b1;
    if (m_slots.size() != 0)
      slot_ok = m_eval(m_slots[0] ? m_bcond : (m_bcond ^ 1));
    e_cond_ex = !reset && instrValid && m_eval(int'(cond)) && slot_ok;
    e_err     = !reset && instrValid && blockStart && (m_slots.size() != 0);
    e_pcsrc   = e_cond_ex && PCS;
    e_regw    = e_cond_ex && regW && !noWrite;
    e_memw    = e_cond_ex && memW;
  endtask

  function automatic logic [12:0] exp_vec();
    return {e_pcsrc, e_regw, e_memw, e_cond_ex, e_err, (m_slots.size() != 0),
            3'(m_slots.size()), m_n, m_z, m_c, m_v};
  endfunction

  task automatic tick();
    model_expect();
    @(posedge clk);
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_slots.delete();
      m_bcond = 0;
    end else begin
      if (e_cond_ex && flagWrite[1]) {m_n, m_z} = aluFlags[3:2];
      if (e_cond_ex && flagWrite[0]) {m_c, m_v} = aluFlags[1:0];
      if (instrValid) begin
        if (m_slots.size() != 0) begin
          void'(m_slots.pop_front());
        end else if (blockStart && e_cond_ex && blockLen != 0) begin
          m_bcond = int'(blockCond);
          for (int i = 0; i < int'(blockLen) && i < MAX_BLOCK; i++)
            m_slots.push_back(blockMask[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; instrValid = 0; cond = 4'd14; aluFlags = 0; flagWrite = 0;
    PCS = 0; regW = 0; memW = 0; noWrite = 0;
    blockStart = 0; blockCond = 0; blockLen = 0; blockMask = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_z();
    instrValid = 1; cond = 4'd14; aluFlags = 4'b0100; flagWrite = 2'b10;
    tick();
    flagWrite = 2'b00; aluFlags = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; instrValid = 1; cond = 4'd14; PCS = 1; regW = 1; memW = 1;
    flagWrite = 2'b11; aluFlags = 4'b1111; blockStart = 1; blockLen = 3;
    #1;
    n_checks++;
    if ({PCSrc, RegWrite, MemWrite, condEx, blockErr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_gated: got %b want 00000",
               {PCSrc, RegWrite, MemWrite, condEx, blockErr});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({flags, blockActive, blockRemain} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b active=%b remain=%0d want all 0",
               flags, blockActive, blockRemain);
    end
  endtask

  task automatic test_eq_basic();
    do_reset();
    instrValid = 1; cond = 4'd0; PCS = 1; regW = 1; memW = 1;
    #1;
    n_checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
      n_fail++;
      $display("FAIL eq_false: got %b want 000", {PCSrc, RegWrite, MemWrite});
    end
    tick();
    cond = 4'd14; aluFlags = 4'b0100; flagWrite = 2'b10;
    tick();
    cond = 4'd0; flagWrite = 0; aluFlags = 0;
    #1;
    n_checks++;
    if ({PCSrc, RegWrite, MemWrite, flags} !== 7'b111_0100) begin
      n_fail++;
      $display("FAIL eq_true: got %b want 1110100", {PCSrc, RegWrite, MemWrite, flags});
    end
    noWrite = 1;
    #1;
    n_checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b101) begin
      n_fail++;
      $display("FAIL no_write: got %b want 101", {PCSrc, RegWrite, MemWrite});
    end
    tick();
  endtask

  task automatic test_split_write();
    do_reset();
    instrValid = 1; cond = 4'd14; aluFlags = 4'b1111; flagWrite = 2'b01;
    tick();
    flagWrite = 0; aluFlags = 0; cond = 4'd10;
    #1;
    n_checks++;
    if ({flags, condEx} !== 5'b0011_0) begin
      n_fail++;
      $display("FAIL split_ge: flags=%b condEx=%b want 0011 0", flags, condEx);
    end
    cond = 4'd11;
    #1;
    n_checks++;
    if (condEx !== 1'b1) begin
      n_fail++;
      $display("FAIL split_lt: condEx=%b want 1", condEx);
    end
    tick();
  endtask

  task automatic test_block();
    bit exp_ex [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    set_z();
    blockStart = 1; blockCond = 4'd0; blockLen = 3; blockMask = 4'b0101;
    tick();
    blockStart = 0; blockLen = 0; blockMask = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({condEx, blockActive, blockRemain} !== {exp_ex[i], 1'b1, 3'(3 - i)}) begin
        n_fail++;
        $display("FAIL block_slot%0d: condEx=%b active=%b remain=%0d want %b 1 %0d",
                 i, condEx, blockActive, blockRemain, exp_ex[i], 3 - i);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({blockActive, blockRemain} !== 4'b0) begin
      n_fail++;
      $display("FAIL block_end: active=%b remain=%0d want 0 0", blockActive, blockRemain);
    end
  endtask

  task automatic test_block_flags();
    do_reset();
    set_z();
    blockStart = 1; blockCond = 4'd0; blockLen = 2; blockMask = 4'b0011;
    tick();
    blockStart = 0; aluFlags = 4'b0000; flagWrite = 2'b10;
    #1;
    n_checks++;
    if (condEx !== 1'b1) begin
      n_fail++;
      $display("FAIL blkflag_slot1: condEx=%b want 1", condEx);
    end
    tick();
    flagWrite = 0;
    #1;
    n_checks++;
    if ({condEx, flags} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL blkflag_slot2: condEx=%b flags=%b want 0 0000", condEx, flags);
    end
    tick();
  endtask

  task automatic test_stall_nest();
    do_reset();
    instrValid = 1; PCS = 1;
    blockStart = 1; blockCond = 4'd14; blockLen = 4; blockMask = 4'b1111;
    tick();
    blockStart = 0;
    tick();
    instrValid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({blockRemain, condEx, PCSrc} !== 5'b011_00) begin
        n_fail++;
        $display("FAIL stall%0d: remain=%0d condEx=%b PCSrc=%b want 3 0 0",
                 i, blockRemain, condEx, PCSrc);
      end
      tick();
    end
    instrValid = 1; blockStart = 1; blockLen = 2;
    #1;
    n_checks++;
    if ({blockErr, blockRemain} !== 4'b1_011) begin
      n_fail++;
      $display("FAIL nest_err: blockErr=%b remain=%0d want 1 3", blockErr, blockRemain);
    end
    tick();
    blockStart = 0;
    #1;
    n_checks++;
    if ({blockErr, blockActive, blockRemain} !== 5'b0_1_010) begin
      n_fail++;
      $display("FAIL nest_after: err=%b active=%b remain=%0d want 0 1 2",
               blockErr, blockActive, blockRemain);
    end
    tick();
    tick();
  endtask

  task automatic test_edges();
    do_reset();
    instrValid = 1; cond = 4'd14; aluFlags = 4'b1010; flagWrite = 2'b11;
    blockStart = 1; blockCond = 4'd14; blockLen = 4; blockMask = 4'b1111;
    tick();
    blockStart = 0; flagWrite = 0;
    tick();
    reset = 1;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({blockActive, blockRemain, flags} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_mid_block: active=%b remain=%0d flags=%b want 0 0 0000",
               blockActive, blockRemain, flags);
    end
    instrValid = 1; blockStart = 1; blockLen = 0; blockMask = 4'b1111;
    tick();
    blockStart = 0;
    #1;
    n_checks++;
    if ({blockActive, blockRemain} !== 4'b0) begin
      n_fail++;
      $display("FAIL len_zero: active=%b remain=%0d want 0 0", blockActive, blockRemain);
    end
    cond = 4'd15; aluFlags = 4'b1111; flagWrite = 2'b11;
    #1;
    n_checks++;
    if (condEx !== 1'b0) begin
      n_fail++;
      $display("FAIL nv_cond: condEx=%b want 0", condEx);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL nv_no_flag: flags=%b want 0000", flags);
    end
  endtask

  task automatic test_random();
    logic [12:0] obs, exp;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      instrValid = ($urandom_range(0, 3) != 0);
      cond       = 4'($urandom_range(0, 15));
      aluFlags   = 4'($urandom);
      flagWrite  = 2'($urandom);
      PCS        = 1'($urandom);
      regW       = 1'($urandom);
      memW       = 1'($urandom);
      noWrite    = ($urandom_range(0, 3) == 0);
      blockStart = ($urandom_range(0, 3) == 0);
      blockLen   = 3'($urandom_range(0, 7));
      blockMask  = 4'($urandom);
      // Keep the base condition stable while a block is open.
      if (m_slots.size() == 0) blockCond = 4'($urandom_range(0, 15));
      else                     blockCond = 4'(m_bcond);
      #1;
      model_expect();
      obs = {PCSrc, RegWrite, MemWrite, condEx, blockErr, blockActive, blockRemain, flags};
      exp = exp_vec();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b (pc,rw,mw,ex,err,act,rem,nzcv)",
                 i, obs, exp);
      end
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_eq_basic();
    test_split_write();
    test_block();
    test_block_flags();
    test_stall_nest();
    test_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
